// File: rtl/ann_pkg.sv
// Shared types and layer-size constants for the ANN datapath and its controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ann_pkg;

    // Layer sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_MAC   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } seq_state_t;

    // Layer geometry shared with the top-level ANN controller
    localparam int IMAGE_SIZE   = 64;
    localparam int FIRST_LAYER  = 16;
    localparam int SECOND_LAYER = 16;
    localparam int THIRD_LAYER  = 10;

endpackage

// File: rtl/ann_idx_counter.sv
// Loadable up-counter with a terminal-count flag; saturates at the terminal value.
// Latency: count and flag update on the edge after load/inc.
// Backpressure: none; load has priority over inc, inc is ignored at terminal count.
module ann_idx_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Count register: never wraps past the terminal value
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/ann_layer_sequencer.sv
// Steps every (node, input) pair of one layer, fetching each coefficient by req/valid.
// Latency: nodes*(2+2*max)+1 cycles from start accept to layer_done with zero-wait coefficients.
// Backpressure: FETCH holds coef_req and addresses until coef_valid; with ANN_SEQ_TIMEOUT_EN a stalled fetch aborts to DONE and sets err.
module ann_layer_sequencer
    import ann_pkg::*;
#(
    parameter int MAX_IN         = 64,
    parameter int MAX_NODES      = 16,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IW = $clog2(MAX_IN),
    localparam int NW = $clog2(MAX_NODES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [6:0]    max_input,
    input  logic [4:0]    num_nodes,
    input  logic          coef_valid,
    output logic          coef_req,
    output logic [IW-1:0] in_addr,
    output logic [NW-1:0] node_addr,
    output logic          clear_accum,
    output logic          mac_en,
    output logic          node_write,
    output logic          busy,
    output logic          layer_done,
    output logic          err
);

    localparam logic [6:0] MAX_IN_C    = 7'(MAX_IN);
    localparam logic [4:0] MAX_NODES_C = 5'(MAX_NODES);

    seq_state_t state, state_nxt;

    logic [6:0]    max_lat;
    logic [4:0]    nodes_lat;
    logic [6:0]    max_clamp;
    logic [4:0]    nodes_clamp;
    logic          start_acc;
    logic          size_zero;
    logic [IW-1:0] in_term;
    logic [NW-1:0] node_term;
    logic          in_tc;
    logic          node_tc;
    logic          timeout;

    // Start is only honoured in IDLE; oversized layers are clamped to the hardware limits
    assign start_acc   = (state == S_IDLE) && start;
    assign max_clamp   = (max_input > MAX_IN_C)    ? MAX_IN_C    : max_input;
    assign nodes_clamp = (num_nodes > MAX_NODES_C) ? MAX_NODES_C : num_nodes;
    assign size_zero   = (max_input == 7'd0) || (num_nodes == 5'd0);

    // Latch the layer geometry on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            max_lat   <= '0;
            nodes_lat <= '0;
        end else if (start_acc) begin
            max_lat   <= max_clamp;
            nodes_lat <= nodes_clamp;
        end
    end

    // Terminal indices; the zero-size case never reaches a compare, so underflow is harmless
    assign in_term   = IW'(max_lat - 7'd1);
    assign node_term = NW'(nodes_lat - 5'd1);

    ann_idx_counter #(.W(IW)) u_in_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc || (state == S_CLEAR)),
        .load_val ('0),
        .inc      (state == S_MAC),
        .term     (in_term),
        .cnt      (in_addr),
        .tc       (in_tc)
    );

    ann_idx_counter #(.W(NW)) u_node_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc),
        .load_val ('0),
        .inc      (state == S_WRITE),
        .term     (node_term),
        .cnt      (node_addr),
        .tc       (node_tc)
    );

`ifdef ANN_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;
    logic          wait_tc;

    // Wait counter restarts from zero on every FETCH entry
    ann_idx_counter #(.W(TW)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state != S_FETCH),
        .load_val ('0),
        .inc      (state == S_FETCH),
        .term     (TW'(TIMEOUT_CYCLES - 1)),
        .cnt      (wait_cnt),
        .tc       (wait_tc)
    );

    assign timeout = (state == S_FETCH) && !coef_valid && wait_tc;

    // Sticky timeout flag, cleared by the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (start_acc) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
    assign err                = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = size_zero ? S_DONE : S_CLEAR;
            S_CLEAR: state_nxt = S_FETCH;
            S_FETCH: begin
                if (coef_valid) begin
                    state_nxt = S_MAC;
                end else if (timeout) begin
                    state_nxt = S_DONE;
                end
            end
            S_MAC:   state_nxt = in_tc ? S_WRITE : S_FETCH;
            S_WRITE: state_nxt = node_tc ? S_DONE : S_CLEAR;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        coef_req    = 1'b0;
        clear_accum = 1'b0;
        mac_en      = 1'b0;
        node_write  = 1'b0;
        layer_done  = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_CLEAR: clear_accum = 1'b1;
            S_FETCH: coef_req    = 1'b1;
            S_MAC:   mac_en      = 1'b1;
            S_WRITE: node_write  = 1'b1;
            S_DONE:  layer_done  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Directed bench for ann_layer_sequencer: reset, layer sequencing, clamping, zero-size, ignored starts, fetch stall.
// Latency: expected cycle counts are hand-computed from the per-node and per-layer formulas.
// Backpressure: coef_valid is driven with a configurable delay after each coef_req.
module tb_ann_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] max_input;
    logic [4:0] num_nodes;
    logic       coef_valid;
    logic       coef_req;
    logic [5:0] in_addr;
    logic [3:0] node_addr;
    logic       clear_accum;
    logic       mac_en;
    logic       node_write;
    logic       busy;
    logic       layer_done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    int n_mac, n_write, n_clear, n_done, done_cyc, addr_unstable;
    logic err_at_done;
    int wr_q[$];

    ann_layer_sequencer #(
        .MAX_IN         (64),
        .MAX_NODES      (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .max_input   (max_input),
        .num_nodes   (num_nodes),
        .coef_valid  (coef_valid),
        .coef_req    (coef_req),
        .in_addr     (in_addr),
        .node_addr   (node_addr),
        .clear_accum (clear_accum),
        .mac_en      (mac_en),
        .node_write  (node_write),
        .busy        (busy),
        .layer_done  (layer_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge of the first cycle after the accept edge
    task automatic do_start(input int m, input int n);
        @(negedge clk);
        start     = 1'b1;
        max_input = 7'(m);
        num_nodes = 5'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Walk one layer cycle by cycle from the current negedge (cycle 1).
    // dly < 0: coef_valid held high; otherwise asserted in FETCH cycle dly+1.
    // pa/pb: cycles in which an extra start pulse is driven.
    task automatic run_layer(input int dly, input int budget, input int pa, input int pb);
        int w;
        logic [5:0] pi;
        logic [3:0] pn;
        bit pf;
        n_mac = 0; n_write = 0; n_clear = 0; n_done = 0; done_cyc = 0;
        addr_unstable = 0; err_at_done = 1'b0; wr_q.delete();
        w = 0; pf = 1'b0; pi = '0; pn = '0;
        for (int c = 1; c <= budget; c++) begin
            start = (c == pa) || (c == pb);
            if (mac_en)      n_mac++;
            if (clear_accum) n_clear++;
            if (node_write) begin
                n_write++;
                wr_q.push_back(int'(node_addr));
            end
            if (coef_req) begin
                if (pf && (in_addr !== pi || node_addr !== pn)) addr_unstable++;
                pi = in_addr; pn = node_addr; pf = 1'b1;
                coef_valid = (dly < 0) || (w >= dly);
                w++;
            end else begin
                pf = 1'b0;
                w  = 0;
                coef_valid = (dly < 0);
            end
            if (layer_done) begin
                n_done++;
                done_cyc    = c;
                err_at_done = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int extra;
        rst = 1'b1; start = 1'b0; max_input = '0; num_nodes = '0; coef_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {25'd0, coef_req, clear_accum, mac_en, node_write, busy, layer_done, err}, 32'd0);
        check("reset_addr", {22'd0, in_addr, node_addr}, 32'd0);
        rst = 1'b0;

        // Reset in the middle of a fetch
        do_start(4, 2);
        coef_valid = 1'b0;
        @(negedge clk);
        check("t1_in_fetch", {31'd0, coef_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t1_rst_first", {29'd0, busy, layer_done, coef_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t1_rst_ctrl", {25'd0, coef_req, clear_accum, mac_en, node_write, busy, layer_done, err}, 32'd0);
        check("t1_rst_addr", {22'd0, in_addr, node_addr}, 32'd0);
        @(negedge clk);
        check("t1_idle_after", {30'd0, busy, layer_done}, 32'd0);

        // 4 inputs x 2 nodes, coef_valid always high
        do_start(4, 2);
        run_layer(-1, 100, 0, 0);
        check("t2_done_cyc", done_cyc, 32'd21);
        check("t2_mac", n_mac, 32'd8);
        check("t2_clear", n_clear, 32'd2);
        check("t2_write", n_write, 32'd2);
        check("t2_wr0", (wr_q.size() > 0) ? wr_q[0] : -1, 32'd0);
        check("t2_wr1", (wr_q.size() > 1) ? wr_q[1] : -1, 32'd1);
        check("t2_err", {31'd0, err_at_done}, 32'd0);
        coef_valid = 1'b0;
        @(negedge clk);
        check("t2_after_done", {30'd0, busy, layer_done}, 32'd0);

        // Full-size layer with three wait cycles per coefficient
        do_start(64, 16);
        run_layer(3, 7000, 0, 0);
        check("t3_done_cyc", done_cyc, 32'd5153);
        check("t3_mac", n_mac, 32'd1024);
        check("t3_write", n_write, 32'd16);
        check("t3_addr_stable", addr_unstable, 32'd0);
        check("t3_last_node", (wr_q.size() == 16) ? wr_q[15] : -1, 32'd15);

        // Oversized inputs clamp to 64
        do_start(100, 1);
        run_layer(0, 500, 0, 0);
        check("clamp_in_done", done_cyc, 32'd131);
        check("clamp_in_mac", n_mac, 32'd64);

        // Oversized node count clamps to 16
        do_start(1, 20);
        run_layer(0, 500, 0, 0);
        check("clamp_node_done", done_cyc, 32'd65);
        check("clamp_node_write", n_write, 32'd16);

        // Zero-size layers go straight to DONE
        do_start(0, 3);
        run_layer(-1, 20, 0, 0);
        check("t4_max0_done", done_cyc, 32'd1);
        check("t4_max0_activity", n_mac + n_clear + n_write, 32'd0);
        coef_valid = 1'b0;
        do_start(5, 0);
        run_layer(0, 20, 0, 0);
        check("t4_nodes0_done", done_cyc, 32'd1);
        check("t4_nodes0_activity", n_mac + n_clear + n_write, 32'd0);

        // Starts during busy (MAC cycle) and in the DONE cycle are ignored
        do_start(2, 1);
        max_input = 7'd9;
        num_nodes = 5'd9;
        run_layer(0, 50, 3, 7);
        check("t5_done_cyc", done_cyc, 32'd7);
        check("t5_mac", n_mac, 32'd2);
        check("t5_write", n_write, 32'd1);
        @(negedge clk);
        start = 1'b0;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (layer_done || busy) extra++;
            @(negedge clk);
        end
        check("t5_no_restart", extra, 32'd0);

`ifdef ANN_SEQ_TIMEOUT_EN
        // Timeout: 8 FETCH cycles without coef_valid abort to DONE with err
        do_start(1, 1);
        run_layer(100000, 40, 0, 0);
        check("t6_to_done_cyc", done_cyc, 32'd10);
        check("t6_to_err", {31'd0, err_at_done}, 32'd1);
        check("t6_to_mac", n_mac, 32'd0);
        @(negedge clk);
        check("t6_err_sticky", {31'd0, err}, 32'd1);
        do_start(0, 1);
        check("t6_err_cleared", {31'd0, err}, 32'd0);
        check("t6_done_after", {31'd0, layer_done}, 32'd1);
`else
        // Without the timeout, FETCH waits indefinitely
        do_start(1, 1);
        coef_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 300; i++) begin
            if (layer_done || err) extra++;
            @(negedge clk);
        end
        check("t6_no_done_no_err", extra, 32'd0);
        check("t6_still_fetch", {30'd0, coef_req, busy}, 32'd3);
        run_layer(0, 20, 0, 0);
        check("t6_finish_cyc", done_cyc, 32'd4);
        check("t6_err_zero", {31'd0, err_at_done}, 32'd0);
`endif

        coef_valid = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
